mdu_hilo: RTL and testbench

Iterative multiply/divide unit owning the HI/LO register pair; it is the responder on the execute stage's multiply/divide interface. The EX stage issues MULT/MULTU/DIV/DIVU/MTHI/MTLO requests with operands and reads HI/LO back for MFHI/MFLO. The EX stage stalls on `Busy`. Sits beside EX, clocked with the pipeline.

---
 rtl/mdu_hilo.sv | 209 ++++++++++++++++++++
 tb/tb_mdu_hilo.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_hilo.sv
// Iterative multiply/divide unit owning HI/LO; shift-add multiply, restoring divide.
// Optional MDU_EARLY_OUT_EN: finish multiply once remaining multiplier bits are zero.
module mdu_hilo #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             Start,
    input  logic [5:0]       Funct,
    input  logic [WIDTH-1:0] Rdata1,
    input  logic [WIDTH-1:0] Rdata2,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO,
    output logic             DivZero
);

    localparam logic [5:0] F_MULT  = 6'h18;
    localparam logic [5:0] F_MULTU = 6'h19;
    localparam logic [5:0] F_DIV   = 6'h1A;
    localparam logic [5:0] F_DIVU  = 6'h1B;
    localparam logic [5:0] F_MTHI  = 6'h11;
    localparam logic [5:0] F_MTLO  = 6'h13;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;
    typedef enum logic [1:0] {K_MUL, K_DIV, K_DZ} kind_t;

    state_t             state_q, state_d;
    kind_t              kind_q, kind_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [5:0]         cnt_q, cnt_d;
    logic               neg_lo_q, neg_lo_d;
    logic               neg_hi_q, neg_hi_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;
    logic               dz_q, dz_d;

    logic               sgn;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     rem_sh, diff;
    logic               ge;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo, rem;

    always_comb begin
        state_d  = state_q;
        kind_d   = kind_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        dz_d     = dz_q;
        done_d   = 1'b0;

        sgn    = (Funct == F_MULT) || (Funct == F_DIV);
        mag_a  = (sgn && Rdata1[WIDTH-1]) ? -Rdata1 : Rdata1;
        mag_b  = (sgn && Rdata2[WIDTH-1]) ? -Rdata2 : Rdata2;
        sum    = '0;
        rem_sh = '0;
        diff   = '0;
        ge     = 1'b0;
        prod   = '0;
        quo    = '0;
        rem    = '0;

        unique case (state_q)
            S_IDLE: begin
                if (Start) begin
                    case (Funct)
                        F_MULT, F_MULTU: begin
                            mcand_d  = mag_a;
                            mplier_d = mag_b;
                            neg_lo_d = sgn & (Rdata1[WIDTH-1] ^ Rdata2[WIDTH-1]);
                            neg_hi_d = 1'b0;
                            acc_d    = '0;
                            cnt_d    = '0;
                            kind_d   = K_MUL;
                            dz_d     = 1'b0;
                            state_d  = S_MUL;
`ifdef MDU_EARLY_OUT_EN
                            if (mag_b == '0)
                                state_d = S_FIX;
`endif
                        end
                        F_DIV, F_DIVU: begin
                            if (Rdata2 == '0) begin
                                dz_d    = 1'b1;
                                kind_d  = K_DZ;
                                state_d = S_FIX;
                            end else begin
                                dz_d     = 1'b0;
                                mcand_d  = mag_b;
                                acc_d    = {{WIDTH{1'b0}}, mag_a};
                                neg_lo_d = sgn & (Rdata1[WIDTH-1] ^ Rdata2[WIDTH-1]);
                                neg_hi_d = sgn & Rdata1[WIDTH-1];
                                cnt_d    = '0;
                                kind_d   = K_DIV;
                                state_d  = S_DIV;
                            end
                        end
                        F_MTHI: begin
                            hi_d = Rdata1;
                            dz_d = 1'b0;
                        end
                        F_MTLO: begin
                            lo_d = Rdata1;
                            dz_d = 1'b0;
                        end
                        default: ;
                    endcase
                end
            end
            S_MUL: begin
                // Accumulator holds the partial product left-aligned to bit 63.
                sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                    + (mplier_q[0] ? {1'b0, mcand_q} : '0);
                acc_d    = {sum, acc_q[WIDTH-1:1]};
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 6'd1;
                if (cnt_q == 6'd31)
                    state_d = S_FIX;
`ifdef MDU_EARLY_OUT_EN
                if (mplier_d == '0)
                    state_d = S_FIX;
`endif
            end
            S_DIV: begin
                rem_sh = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
                diff   = rem_sh - {1'b0, mcand_q};
                ge     = ~diff[WIDTH];
                acc_d  = {(ge ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0]),
                          acc_q[WIDTH-2:0], ge};
                cnt_d  = cnt_q + 6'd1;
                if (cnt_q == 6'd31)
                    state_d = S_FIX;
            end
            S_FIX: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
                case (kind_q)
                    K_MUL: begin
`ifdef MDU_EARLY_OUT_EN
                        prod = acc_q >> (6'd32 - cnt_q);
`else
                        prod = acc_q;
`endif
                        if (neg_lo_q)
                            prod = -prod;
                        hi_d = prod[2*WIDTH-1:WIDTH];
                        lo_d = prod[WIDTH-1:0];
                    end
                    K_DIV: begin
                        quo  = acc_q[WIDTH-1:0];
                        rem  = acc_q[2*WIDTH-1:WIDTH];
                        lo_d = neg_lo_q ? -quo : quo;
                        hi_d = neg_hi_q ? -rem : rem;
                    end
                    default: ;
                endcase
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= S_IDLE;
            kind_q   <= K_MUL;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
            dz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            kind_q   <= kind_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
            dz_q     <= dz_d;
        end
    end

    assign Busy    = (state_q != S_IDLE);
    assign Done    = done_q;
    assign HI      = hi_q;
    assign LO      = lo_q;
    assign DivZero = dz_q;

endmodule

// File: tb/tb_mdu_hilo.sv
// Scoreboard bench for mdu_hilo: expected HI/LO/latency queued at issue, checked at Done.
// Build with +define+MDU_EARLY_OUT_EN to match an early-out DUT build.
module tb_mdu_hilo;

    logic        CLK = 1'b0;
    logic        RST;
    logic        Start;
    logic [5:0]  Funct;
    logic [31:0] Rdata1, Rdata2;
    logic        Busy, Done, DivZero;
    logic [31:0] HI, LO;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
        logic        dz;
    } exp_t;

    exp_t sb[$];
    logic [31:0] m_hi, m_lo;

    mdu_hilo #(.WIDTH(32)) dut (
        .CLK(CLK), .RST(RST), .Start(Start), .Funct(Funct),
        .Rdata1(Rdata1), .Rdata2(Rdata2), .Busy(Busy), .Done(Done),
        .HI(HI), .LO(LO), .DivZero(DivZero)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int mul_lat(input logic [5:0] f, input logic [31:0] b);
        logic [31:0] mag;
        int msb;
        mag = (f == 6'h18 && b[31]) ? -b : b;
        msb = -1;
        for (int i = 0; i < 32; i++)
            if (mag[i]) msb = i;
`ifdef MDU_EARLY_OUT_EN
        return (msb < 0) ? 1 : msb + 2;
`else
        return 33;
`endif
    endfunction

    function automatic exp_t model(input logic [5:0] f, input logic [31:0] a,
                                   input logic [31:0] b);
        exp_t e;
        logic signed [63:0] sp;
        logic [63:0] up;
        int sa, sbv;
        e.hi = m_hi;
        e.lo = m_lo;
        e.lat = 33;
        e.dz = 1'b0;
        case (f)
            6'h18: begin
                sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
                {e.hi, e.lo} = sp;
                e.lat = mul_lat(f, b);
            end
            6'h19: begin
                up = {32'b0, a} * {32'b0, b};
                {e.hi, e.lo} = up;
                e.lat = mul_lat(f, b);
            end
            default: begin
                if (b == 0) begin
                    e.dz = 1'b1;
                    e.lat = 1;
                end else if (f == 6'h1A) begin
                    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                        e.lo = 32'h8000_0000;
                        e.hi = 32'h0;
                    end else begin
                        sa = a;
                        sbv = b;
                        e.lo = sa / sbv;
                        e.hi = sa % sbv;
                    end
                end else begin
                    e.lo = a / b;
                    e.hi = a % b;
                end
            end
        endcase
        return e;
    endfunction

    task automatic run_op(input logic [5:0] f, input logic [31:0] a,
                          input logic [31:0] b);
        exp_t e;
        int k, bcnt;
        bit got;
        e = model(f, a, b);
        sb.push_back(e);
        Start = 1'b1;
        Funct = f;
        Rdata1 = a;
        Rdata2 = b;
        @(posedge CLK);
        @(negedge CLK);
        Start = 1'b0;
        k = 0;
        bcnt = 0;
        got = 0;
        while (k < 100 && !got) begin
            if (Done) begin
                got = 1;
            end else begin
                if (Busy) bcnt++;
                chk("hold_hi", HI, m_hi);
                k++;
                @(negedge CLK);
            end
        end
        chk("done_seen", got, 1);
        e = sb.pop_front();
        chk("hi", HI, e.hi);
        chk("lo", LO, e.lo);
        chk("latency", k, e.lat);
        chk("busy_cycles", bcnt, e.lat);
        chk("divzero", DivZero, e.dz);
        chk("busy_at_done", Busy, 0);
        m_hi = e.hi;
        m_lo = e.lo;
        @(negedge CLK);
        chk("done_pulse", Done, 0);
    endtask

    task automatic mt(input logic [5:0] f, input logic [31:0] d);
        Start = 1'b1;
        Funct = f;
        Rdata1 = d;
        Rdata2 = 32'h0;
        @(posedge CLK);
        @(negedge CLK);
        Start = 1'b0;
        if (f == 6'h11) m_hi = d;
        else m_lo = d;
        chk("mt_hi", HI, m_hi);
        chk("mt_lo", LO, m_lo);
        chk("mt_busy", Busy, 0);
        chk("mt_done", Done, 0);
        @(negedge CLK);
        chk("mt_done2", Done, 0);
    endtask

    initial begin
        logic [5:0] fs [4];
        logic [31:0] a, b, ab_b;
        int dn;
        fs[0] = 6'h18; fs[1] = 6'h19; fs[2] = 6'h1A; fs[3] = 6'h1B;
        RST = 1'b1;
        Start = 1'b0;
        Funct = 6'h0;
        Rdata1 = 32'h0;
        Rdata2 = 32'h0;
        m_hi = 32'h0;
        m_lo = 32'h0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        chk("rst_hi", HI, 0);
        chk("rst_lo", LO, 0);
        chk("rst_busy", Busy, 0);
        chk("rst_done", Done, 0);
        chk("rst_dz", DivZero, 0);
        RST = 1'b0;
        @(negedge CLK);

        run_op(6'h18, 32'hFFFF_FFFF, 32'd3);
        chk("mult_neg_hi", m_hi, 32'hFFFF_FFFF);
        chk("mult_neg_lo", m_lo, 32'hFFFF_FFFD);
        run_op(6'h19, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op(6'h1B, 32'd7, 32'd2);
        run_op(6'h1A, 32'hFFFF_FFF9, 32'd2);
        run_op(6'h1A, 32'h8000_0000, 32'hFFFF_FFFF);

        mt(6'h11, 32'h1234_5678);
        run_op(6'h1A, 32'd5, 32'd0);
        chk("dz_hi_kept", HI, 32'h1234_5678);
        chk("dz_sticky", DivZero, 1);
        run_op(6'h18, 32'd3, 32'd4);
        mt(6'h13, 32'h0BAD_F00D);

        run_op(6'h19, 32'd1, 32'd1);
        run_op(6'h19, 32'd5, 32'd0);
        run_op(6'h18, 32'h8000_0000, 32'h8000_0000);

        for (int i = 0; i < 10; i++) begin
            a = $urandom;
            b = (i % 3 == 0) ? $urandom_range(1, 300) : $urandom;
            run_op(fs[i % 4], a, b);
        end

        // Mid-operation ignored Start, then abort by reset.
`ifdef MDU_EARLY_OUT_EN
        ab_b = 32'h7000_0007;
`else
        ab_b = 32'd7;
`endif
        Start = 1'b1;
        Funct = 6'h18;
        Rdata1 = 32'd6;
        Rdata2 = ab_b;
        @(posedge CLK);
        @(negedge CLK);
        Start = 1'b0;
        repeat (4) @(negedge CLK);
        Start = 1'b1;
        Funct = 6'h13;
        Rdata1 = 32'h0000_AAAA;
        @(negedge CLK);
        Start = 1'b0;
        chk("busy_start_lo", LO, m_lo);
        chk("busy_start_busy", Busy, 1);
        repeat (4) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        chk("abort_hi", HI, 0);
        chk("abort_lo", LO, 0);
        chk("abort_busy", Busy, 0);
        chk("abort_done", Done, 0);
        m_hi = 32'h0;
        m_lo = 32'h0;
        dn = 0;
        repeat (40) begin
            @(negedge CLK);
            if (Done) dn++;
        end
        chk("abort_no_done", dn, 0);

        run_op(6'h1B, 32'd100, 32'd7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
